// File: rtl/xeng_vacc.sv
// xeng_vacc: long-term vector accumulator behind the X-engine.
// Each baseline/bin word (8 signed components) is summed over acc_len
// windows in block RAM. The last window of each accumulation is streamed out
// as the finished vector, together with valid, sync and the mcnt of window 0.
module xeng_vacc #(
    parameter int VEC_LEN     = 544,
    parameter int IN_W        = 19,
    parameter int OUT_W       = 32,
    parameter int ACC_LEN_W   = 16,
    parameter int MCNT_WIDTH  = 48,
    parameter int RAM_LATENCY = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sync_in,
    input  logic [8*IN_W-1:0]       din,
    input  logic                    vld,
    input  logic [MCNT_WIDTH-1:0]   mcnt,
    input  logic [ACC_LEN_W-1:0]    acc_len,
    output logic [8*OUT_W-1:0]      dout,
    output logic                    vld_out,
    output logic                    sync_out,
    output logic [MCNT_WIDTH-1:0]   mcnt_out,
    output logic                    sat,
    output logic                    dbg_state
);

    localparam int AW = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
    localparam int P  = RAM_LATENCY - 1;   // pipeline slot aligned with RAM read data

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_ACC  = 1'b1;

    localparam logic [AW-1:0]        LAST_ADDR = AW'(VEC_LEN - 1);
    localparam logic [ACC_LEN_W-1:0] LEN_ONE   = ACC_LEN_W'(1);

    // Handshake: a word is accepted on any cycle where vld is high and the
    // block is accumulating (or sync_in arrives in the same cycle). There is
    // no backpressure; vld_out marks each emitted word for exactly one cycle.

    logic [0:0]           r_state;
    logic [AW-1:0]        r_addr;
    logic [ACC_LEN_W-1:0] r_win;
    logic [ACC_LEN_W-1:0] r_len;

    logic [ACC_LEN_W-1:0] w_len_in;
    logic [AW-1:0]        w_cur_addr;
    logic [ACC_LEN_W-1:0] w_cur_win;
    logic [ACC_LEN_W-1:0] w_cur_len;
    logic                 w_accept;
    logic                 w_first;
    logic                 w_dump;
    logic                 w_cap;

    // Pipeline that carries each accepted word's control alongside the RAM read
    logic                  r_p_vld   [RAM_LATENCY];
    logic                  r_p_sync  [RAM_LATENCY];
    logic                  r_p_first [RAM_LATENCY];
    logic                  r_p_dump  [RAM_LATENCY];
    logic                  r_p_cap   [RAM_LATENCY];
    logic [AW-1:0]         r_p_addr  [RAM_LATENCY];
    logic [8*IN_W-1:0]     r_p_din   [RAM_LATENCY];
    logic [MCNT_WIDTH-1:0] r_p_mcnt  [RAM_LATENCY];
    logic [8*OUT_W-1:0]    r_rd      [RAM_LATENCY];

    logic [8*OUT_W-1:0]    r_mem [VEC_LEN];

    logic [8*OUT_W-1:0]    w_sum;
    logic                  w_any_sat;
    logic [OUT_W:0]        w_a;
    logic [OUT_W:0]        w_b;
    logic [OUT_W:0]        w_s;

    assign dbg_state = r_state;

    // A sync_in restarts counting immediately, so the coincident word is addr 0 of window 0
    always_comb begin
        w_len_in   = (acc_len == '0) ? LEN_ONE : acc_len;
        w_cur_addr = sync_in ? '0 : r_addr;
        w_cur_win  = sync_in ? '0 : r_win;
        w_cur_len  = sync_in ? w_len_in : r_len;
        w_accept   = vld && (sync_in || (r_state == S_ACC));
        w_first    = (w_cur_win == '0);
        w_dump     = (w_cur_win == (w_cur_len - LEN_ONE));
        w_cap      = w_first && (w_cur_addr == '0);
    end

    // State, address and window counters; they advance only on accepted words
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_win   <= '0;
            r_len   <= '0;
        end else begin
            if (sync_in) begin
                r_state <= S_ACC;
                r_len   <= w_len_in;
            end
            if (w_accept) begin
                if (w_cur_addr == LAST_ADDR) begin
                    r_addr <= '0;
                    r_win  <= w_dump ? '0 : (w_cur_win + LEN_ONE);
                end else begin
                    r_addr <= w_cur_addr + AW'(1);
                    r_win  <= w_cur_win;
                end
            end else if (sync_in) begin
                r_addr <= '0;
                r_win  <= '0;
            end
        end
    end

    // Valid and sync delay lines; reset drops any words in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < RAM_LATENCY; k++) begin
                r_p_vld[k]  <= 1'b0;
                r_p_sync[k] <= 1'b0;
            end
        end else begin
            r_p_vld[0]  <= w_accept;
            r_p_sync[0] <= sync_in;
            for (int k = 1; k < RAM_LATENCY; k++) begin
                r_p_vld[k]  <= r_p_vld[k-1];
                r_p_sync[k] <= r_p_sync[k-1];
            end
        end
    end

    // Data-side delay lines, qualified by r_p_vld so they need no reset
    always_ff @(posedge clk) begin
        r_p_first[0] <= w_first;
        r_p_dump[0]  <= w_dump;
        r_p_cap[0]   <= w_cap;
        r_p_addr[0]  <= w_cur_addr;
        r_p_din[0]   <= din;
        r_p_mcnt[0]  <= mcnt;
        for (int k = 1; k < RAM_LATENCY; k++) begin
            r_p_first[k] <= r_p_first[k-1];
            r_p_dump[k]  <= r_p_dump[k-1];
            r_p_cap[k]   <= r_p_cap[k-1];
            r_p_addr[k]  <= r_p_addr[k-1];
            r_p_din[k]   <= r_p_din[k-1];
            r_p_mcnt[k]  <= r_p_mcnt[k-1];
        end
    end

    // Accumulator RAM: pipelined read, write-back of non-dump partial sums.
    // An address is revisited only after VEC_LEN >= 8 words, so no forwarding.
    always_ff @(posedge clk) begin
        r_rd[0] <= r_mem[w_cur_addr];
        for (int k = 1; k < RAM_LATENCY; k++) begin
            r_rd[k] <= r_rd[k-1];
        end
        if (r_p_vld[P] && !r_p_dump[P]) begin
            r_mem[r_p_addr[P]] <= w_sum;
        end
    end

    // Per-component add with independent saturation to OUT_W
    always_comb begin
        w_sum     = '0;
        w_any_sat = 1'b0;
        w_a       = '0;
        w_b       = '0;
        w_s       = '0;
        for (int i = 0; i < 8; i++) begin
            w_a = {{(OUT_W + 1 - IN_W){r_p_din[P][i*IN_W + IN_W - 1]}},
                   r_p_din[P][i*IN_W +: IN_W]};
            w_b = r_p_first[P] ? '0 :
                  {r_rd[P][i*OUT_W + OUT_W - 1], r_rd[P][i*OUT_W +: OUT_W]};
            w_s = w_a + w_b;
            if (w_s[OUT_W] != w_s[OUT_W-1]) begin
                w_any_sat = 1'b1;
                w_sum[i*OUT_W +: OUT_W] = w_s[OUT_W] ? {1'b1, {(OUT_W-1){1'b0}}}
                                                     : {1'b0, {(OUT_W-1){1'b1}}};
            end else begin
                w_sum[i*OUT_W +: OUT_W] = w_s[OUT_W-1:0];
            end
        end
    end

    // Output register: dump words, aligned sync, window-0 mcnt and sticky saturation
    always_ff @(posedge clk) begin
        if (rst) begin
            dout     <= '0;
            vld_out  <= 1'b0;
            sync_out <= 1'b0;
            mcnt_out <= '0;
            sat      <= 1'b0;
        end else begin
            vld_out  <= r_p_vld[P] && r_p_dump[P];
            sync_out <= r_p_sync[P];
            if (r_p_vld[P] && r_p_dump[P]) begin
                dout <= w_sum;
            end
            if (r_p_vld[P] && r_p_cap[P]) begin
                mcnt_out <= r_p_mcnt[P];
            end
            if (sync_in) begin
                sat <= 1'b0;
            end else if (r_p_vld[P] && w_any_sat) begin
                sat <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_xeng_vacc.sv
// Bench for xeng_vacc: two instances share one stimulus stream, one with
// 16-bit sums (sign extension path) and one with 8-bit sums (saturation path).
module tb_xeng_vacc;

    localparam int VL  = 8;
    localparam int LAT = 3;

    logic         clk = 1'b0;
    logic         rst, sync_in, vld;
    logic [63:0]  din;
    logic [47:0]  mcnt;
    logic [15:0]  acc_len;

    logic [127:0] dout_a;
    logic         vld_out_a, sync_out_a, sat_a, dbg_a;
    logic [47:0]  mcnt_out_a;
    logic [63:0]  dout_b;
    logic         vld_out_b, sync_out_b, sat_b, dbg_b;
    logic [47:0]  mcnt_out_b;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    xeng_vacc #(.VEC_LEN(VL), .IN_W(8), .OUT_W(16), .ACC_LEN_W(16),
                .MCNT_WIDTH(48), .RAM_LATENCY(2)) dut_a (
        .clk(clk), .rst(rst), .sync_in(sync_in), .din(din), .vld(vld),
        .mcnt(mcnt), .acc_len(acc_len), .dout(dout_a), .vld_out(vld_out_a),
        .sync_out(sync_out_a), .mcnt_out(mcnt_out_a), .sat(sat_a),
        .dbg_state(dbg_a));

    xeng_vacc #(.VEC_LEN(VL), .IN_W(8), .OUT_W(8), .ACC_LEN_W(16),
                .MCNT_WIDTH(48), .RAM_LATENCY(2)) dut_b (
        .clk(clk), .rst(rst), .sync_in(sync_in), .din(din), .vld(vld),
        .mcnt(mcnt), .acc_len(acc_len), .dout(dout_b), .vld_out(vld_out_b),
        .sync_out(sync_out_b), .mcnt_out(mcnt_out_b), .sat(sat_b),
        .dbg_state(dbg_b));

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_pass   = 0;
    int edge_cnt = 0;
    bit checking = 1'b0;

    logic        nx_rst = 1'b1;
    logic [47:0] nx_mcnt = '0;
    logic [15:0] nx_len = '0;

    typedef struct packed {
        logic [31:0]  due;
        logic [127:0] e16;
        logic [63:0]  e8;
        logic [47:0]  mc;
    } exp_t;

    exp_t exp_q[$];
    int   sync_q[$];

    // behavioural model state
    bit          m_acc = 1'b0;
    int          m_addr, m_win, m_len;
    logic [47:0] m_mcnt;
    int          acc16 [8][8];
    int          acc8  [8][8];

    // per-phase observations
    int           ph_cnt;
    int           ph_first;
    logic [127:0] ph_first_a;
    logic [127:0] ph_last_a;
    logic [63:0]  ph_last_b;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, edge_cnt);
    endtask

    function automatic int satw(input int s, input int w);
        int hi, lo;
        hi = (1 << (w - 1)) - 1;
        lo = -(1 << (w - 1));
        if (s > hi) return hi;
        if (s < lo) return lo;
        return s;
    endfunction

    function automatic logic [63:0] all8(input int v);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[i*8 +: 8] = v[7:0];
        return r;
    endfunction

    function automatic logic [127:0] all16(input int v);
        logic [127:0] r;
        for (int i = 0; i < 8; i++) r[i*16 +: 16] = v[15:0];
        return r;
    endfunction

    // distinct value per component: i*3-10
    function automatic logic [63:0] ramp8();
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[i*8 +: 8] = 8'(i * 3 - 10);
        return r;
    endfunction

    // Model of one clock edge, applied to the inputs that edge sampled
    task automatic model_edge(input int cyc);
        exp_t e;
        int   x;
        if (rst) begin
            exp_q.delete();
            sync_q.delete();
            m_acc = 1'b0;
        end else begin
            if (sync_in) begin
                sync_q.push_back(cyc + LAT);
                m_acc  = 1'b1;
                m_addr = 0;
                m_win  = 0;
                m_len  = (acc_len == 16'd0) ? 1 : int'(acc_len);
            end
            if (vld && m_acc) begin
                if (m_win == 0 && m_addr == 0) m_mcnt = mcnt;
                e = '0;
                e.due = 32'(cyc + LAT);
                e.mc  = m_mcnt;
                for (int c = 0; c < 8; c++) begin
                    x = int'($signed(din[c*8 +: 8]));
                    if (m_win == 0) begin
                        acc16[m_addr][c] = satw(x, 16);
                        acc8[m_addr][c]  = satw(x, 8);
                    end else begin
                        acc16[m_addr][c] = satw(acc16[m_addr][c] + x, 16);
                        acc8[m_addr][c]  = satw(acc8[m_addr][c] + x, 8);
                    end
                    e.e16[c*16 +: 16] = acc16[m_addr][c][15:0];
                    e.e8[c*8 +: 8]    = acc8[m_addr][c][7:0];
                end
                if (m_win == m_len - 1) exp_q.push_back(e);
                if (m_addr == VL - 1) begin
                    m_addr = 0;
                    m_win  = (m_win == m_len - 1) ? 0 : m_win + 1;
                end else begin
                    m_addr = m_addr + 1;
                end
            end
        end
    endtask

    // ---------------- driver ----------------
    task automatic drive_cycle(input bit s, input bit v, input logic [63:0] d);
        int cyc;
        #1;
        rst     = nx_rst;
        sync_in = s;
        vld     = v;
        din     = d;
        mcnt    = nx_mcnt;
        acc_len = nx_len;
        cyc     = edge_cnt;
        @(posedge clk);
        edge_cnt++;
        model_edge(cyc);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_cycle(1'b0, 1'b0, 64'd0);
    endtask

    task automatic start_phase();
        ph_cnt   = 0;
        ph_first = -1;
    endtask

    // ---------------- scoreboard compare ----------------
    always @(negedge clk) begin
        bit   ev, es;
        exp_t e;
        if (checking) begin
            ev = (exp_q.size() > 0) && (int'(exp_q[0].due) == edge_cnt);
            check("vld_out_a", vld_out_a, ev);
            check("vld_out_b", vld_out_b, ev);
            if (ev) begin
                e = exp_q.pop_front();
                check("dout_a", dout_a, e.e16);
                check("dout_b", dout_b, e.e8);
                check("mcnt_out_a", mcnt_out_a, e.mc);
                check("mcnt_out_b", mcnt_out_b, e.mc);
            end
            es = (sync_q.size() > 0) && (sync_q[0] == edge_cnt);
            check("sync_out_a", sync_out_a, es);
            check("sync_out_b", sync_out_b, es);
            if (es) void'(sync_q.pop_front());
            if (vld_out_a) begin
                if (ph_first < 0) begin
                    ph_first   = edge_cnt;
                    ph_first_a = dout_a;
                end
                ph_cnt++;
                ph_last_a = dout_a;
                ph_last_b = dout_b;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int w24c;
        logic [127:0] ramp_acc;
        rst = 1'b1; sync_in = 1'b0; vld = 1'b0; din = '0; mcnt = '0; acc_len = '0;

        // reset
        nx_rst = 1'b1;
        idle(3);
        nx_rst = 1'b0;
        @(negedge clk);
        check("reset dout_a", dout_a, 0);
        check("reset vld_out_a", vld_out_a, 0);
        check("reset mcnt_out_a", mcnt_out_a, 0);
        check("reset sat_b", sat_b, 0);
        check("reset state", dbg_a, 0);
        checking = 1'b1;

        // 1: acc_len=4, all components 3 -> 12, first dump LAT after word 24
        nx_len = 16'd4;
        start_phase();
        nx_mcnt = 48'd100;
        drive_cycle(1'b1, 1'b0, 64'd0);
        @(negedge clk);
        check("state after sync", dbg_a, 1);
        w24c = 0;
        for (int w = 0; w < 32; w++) begin
            nx_mcnt = 48'(100 + w / 8);
            if (w == 24) w24c = edge_cnt;
            drive_cycle(1'b0, 1'b1, all8(3));
        end
        idle(6);
        check("p1 pulses", ph_cnt, 8);
        check("p1 first pulse cycle", ph_first, w24c + LAT);
        check("p1 dout_a", ph_last_a, all16(12));
        check("p1 dout_b", ph_last_b, all8(12));
        check("p1 mcnt_out", mcnt_out_a, 48'd100);
        check("p1 sat_a", sat_a, 0);

        // 2: acc_len=3, components addr-4, sync with first word, vld gaps
        nx_len = 16'd3;
        start_phase();
        for (int w = 0; w < 24; w++) begin
            nx_mcnt = 48'(200 + w / 8);
            if (w % 3 == 2) idle(1);
            drive_cycle(w == 0, 1'b1, all8((w % VL) - 4));
        end
        idle(6);
        check("p2 pulses", ph_cnt, 8);
        check("p2 first dout_a", ph_first_a, all16(-12));
        check("p2 last dout_a", ph_last_a, all16(9));
        check("p2 last dout_b", ph_last_b, all8(9));
        check("p2 mcnt_out", mcnt_out_a, 48'd200);
        check("p2 sat_a", sat_a, 0);
        check("p2 sat_b", sat_b, 0);

        // 3: acc_len=2, components 100 -> 200 on 16 bits, 127 saturated on 8 bits
        nx_len = 16'd2;
        start_phase();
        nx_mcnt = 48'd300;
        drive_cycle(1'b1, 1'b0, 64'd0);
        for (int w = 0; w < 16; w++) drive_cycle(1'b0, 1'b1, all8(100));
        idle(6);
        check("p3 pulses", ph_cnt, 8);
        check("p3 dout_a", ph_last_a, all16(200));
        check("p3 dout_b", ph_last_b, all8(127));
        check("p3 sat_a", sat_a, 0);
        check("p3 sat_b", sat_b, 1);
        drive_cycle(1'b1, 1'b0, 64'd0);
        @(negedge clk);
        check("p3 sat_b cleared", sat_b, 0);
        idle(2);

        // 4: acc_len=0, every window dumped as sign-extended input
        nx_len = 16'd0;
        start_phase();
        for (int w = 0; w < 16; w++) begin
            nx_mcnt = 48'(400 + w / 8);
            drive_cycle(w == 0, 1'b1, all8(-5));
        end
        idle(6);
        check("p4 pulses", ph_cnt, 16);
        check("p4 dout_a", ph_last_a, all16(-5));
        check("p4 dout_b", ph_last_b, all8(-5));
        check("p4 mcnt_out", mcnt_out_a, 48'd401);

        // 5: acc_len=4, restart after 13 words; only the second run dumps
        nx_len = 16'd4;
        start_phase();
        nx_mcnt = 48'd500;
        drive_cycle(1'b1, 1'b0, 64'd0);
        for (int w = 0; w < 13; w++) begin
            nx_mcnt = 48'(500 + w / 8);
            drive_cycle(1'b0, 1'b1, all8(1));
        end
        for (int w = 0; w < 32; w++) begin
            nx_mcnt = 48'(600 + w / 8);
            drive_cycle(w == 0, 1'b1, ramp8());
        end
        idle(6);
        for (int i = 0; i < 8; i++) ramp_acc[i*16 +: 16] = 16'(4 * (i * 3 - 10));
        check("p5 pulses", ph_cnt, 8);
        check("p5 dout_a", ph_last_a, ramp_acc);
        check("p5 mcnt_out", mcnt_out_a, 48'd600);

        // 6: reset at word 20, ignored words, then a clean accumulation
        start_phase();
        nx_mcnt = 48'd700;
        drive_cycle(1'b1, 1'b0, 64'd0);
        for (int w = 0; w < 20; w++) drive_cycle(1'b0, 1'b1, all8(1));
        nx_rst = 1'b1;
        drive_cycle(1'b0, 1'b1, all8(1));
        nx_rst = 1'b0;
        @(negedge clk);
        check("p6 reset dout_a", dout_a, 0);
        check("p6 reset vld_out_a", vld_out_a, 0);
        check("p6 reset mcnt_out_a", mcnt_out_a, 0);
        check("p6 reset state", dbg_a, 0);
        for (int w = 0; w < 8; w++) drive_cycle(1'b0, 1'b1, all8(7));
        idle(4);
        check("p6 ignored words", ph_cnt, 0);
        nx_mcnt = 48'd800;
        drive_cycle(1'b1, 1'b0, 64'd0);
        for (int w = 0; w < 32; w++) begin
            nx_mcnt = 48'(800 + w / 8);
            drive_cycle(1'b0, 1'b1, all8(2));
        end
        idle(6);
        check("p6 pulses", ph_cnt, 8);
        check("p6 dout_a", ph_last_a, all16(8));
        check("p6 mcnt_out", mcnt_out_a, 48'd800);
        check("leftover expected words", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/xeng_vacc.md
Name: xeng_vacc

Overview:
Long-term vector accumulator directly downstream of xeng_top. It consumes the per-baseline 4-Stokes complex output words (dout/vld_out/sync_out/mcnt_out of the X-engine) and sums each baseline/bin word over a runtime-programmable number of X-engine windows in block RAM. At the end of each accumulation it emits one full summed vector with matching valid, sync and mcnt. Its output feeds the packetiser.

Parameters:
VEC_LEN, 544, words per X-engine output window (N_ANTS*(N_ANTS/2+1) for 32 ants); must be >= 8
IN_W, 19, signed width of each of the 8 input components (corrected xeng output)
OUT_W, 32, signed width of each of the 8 accumulated components; OUT_W >= IN_W
ACC_LEN_W, 16, width of acc_len
MCNT_WIDTH, 48, mcnt bus width
RAM_LATENCY, 2, BRAM read latency in cycles

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
sync_in  in  1  X-engine sync_out; starts a new accumulation
din  in  8*IN_W  {xx_r,xx_i,xy_r,xy_i,yx_r,yx_i,yy_r,yy_i}, MSB first, signed
vld  in  1  din valid
mcnt  in  MCNT_WIDTH  timestamp of the current window
acc_len  in  ACC_LEN_W  windows per accumulation; latched on sync_in
dout  out  8*OUT_W  accumulated components, same order as din
vld_out  out  1  dout valid
sync_out  out  1  sync aligned to the output pipeline
mcnt_out  out  MCNT_WIDTH  mcnt of the first window in the dumped accumulation
sat  out  1  sticky: some component saturated since the last sync_in

Behaviour:
- Single clock domain. Reset is synchronous and active-high.
- Reset: dout=0, vld_out=0, sync_out=0, mcnt_out=0, sat=0, state IDLE, all counters 0. RAM contents are don't-care. Reset mid-accumulation discards all partial sums.
- States:
  - IDLE: vld is ignored.
  - ACC: entered on sync_in. Every sync_in, from either state, goes to ACC, clears addr, win_cnt and sat, and latches acc_len_l = max(acc_len,1).
- Counters:
  - addr (0..VEC_LEN-1) increments on each vld word in ACC and wraps at VEC_LEN-1.
  - On wrap, win_cnt increments. It wraps to 0 when win_cnt == acc_len_l-1.
  - vld gaps are allowed. Counters advance only on vld.
- Per-word datapath, one read-modify-write per accepted word:
  - win_cnt==0: sum = sign-extended din. RAM read data is ignored.
  - Otherwise: sum = RAM[addr] + sign-extended din.
  - Each of the 8 components saturates independently to [-2^(OUT_W-1), 2^(OUT_W-1)-1]. Any saturation sets sat.
  - win_cnt < acc_len_l-1: write sum to RAM[addr]. vld_out stays low.
  - win_cnt == acc_len_l-1 (the dump window): drive sum on dout with vld_out=1. No RAM write is needed.
- Latency: LAT = RAM_LATENCY+1 cycles from an accepted input word to its dout/vld_out.
  - sync_out is sync_in delayed by LAT cycles.
  - Every input-side control signal (addr, win_cnt flags, vld) is delayed by LAT to align with RAM data.
- Hazard: an address is revisited only after VEC_LEN >= 8 accepted words, which exceeds LAT. No forwarding path is required.
- mcnt_out: capture mcnt on the first accepted word of window 0. Present it on mcnt_out LAT cycles later and hold it until the next capture reaches the output.
- acc_len=1 or 0: every window is dumped; dout = sign-extended din after LAT cycles.
- sync_in coinciding with vld: the word is accepted as addr 0 of window 0 of the new accumulation.
- sync_in mid-dump: dump words already in the pipeline still emerge; no further words of the old dump are emitted.
- vld_out is exactly VEC_LEN pulses per completed accumulation, in input order.
- acc_len changes take effect only at the next sync_in.

Test Plan:
- VEC_LEN=8, acc_len=4, sync then 32 vld words with every component =3 -> exactly 8 vld_out pulses; every component =12; first pulse LAT cycles after input word 24.
- Same setup, components = addr-4 (-4..3), acc_len=3 -> dout components -12,-9,...,9 in addr order; sat=0.
- OUT_W=IN_W=8, components =100, acc_len=2 -> dout=127 on every component, sat=1. Next sync_in -> sat=0.
- acc_len=0, components =-5 -> dout=-5 on every accepted word, vld_out continuous; mcnt_out updates at every window start.
- acc_len=4, second sync_in after 13 words -> no vld_out from the aborted run; next dump at 32 words after the second sync; mcnt_out = mcnt of the second sync's first word.
- rst asserted at word 20 of 32 -> outputs 0 next cycle; vld ignored until a new sync_in; the next accumulation dumps correct totals.
